// File: rtl/mips_multicycle_control_if.sv
// Bus between the multi-cycle MIPS control FSM and its datapath/memory.
// The master side is the controller; the slave side is datapath + memory.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;

    logic       mem_req;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       IorD;
    logic       RegWrite;
    logic       MemToReg;
    logic       ALUSrcA;
    logic       unsigned_op;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] Branch;
    logic [1:0] RegDst;
    logic [1:0] MEM_size;
    logic [4:0] ALUControl;
    logic [3:0] state;
    logic       instr_done;
    logic       error;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, MemWrite, IRWrite, PCWrite, IorD, RegWrite, MemToReg,
               ALUSrcA, unsigned_op, ALUSrcB, PCSource, Branch, RegDst,
               MEM_size, ALUControl, state, instr_done, error
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, MemWrite, IRWrite, PCWrite, IorD, RegWrite, MemToReg,
               ALUSrcA, unsigned_op, ALUSrcB, PCSource, Branch, RegDst,
               MEM_size, ALUControl, state, instr_done, error
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back over one shared memory port with a bounded-wait handshake.
// Illegal instructions and memory timeouts park the FSM in a sticky TRAP.
module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic                       clk,
    input logic                       rst_n,
    mips_multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
        S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
        S_I_EXEC = 4'd8, S_I_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
        S_TRAP = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req, MemWrite, IRWrite, PCWrite, IorD;
        logic       RegWrite, MemToReg, ALUSrcA, unsigned_op;
        logic [1:0] ALUSrcB, PCSource;
        logic [2:0] Branch;
        logic [1:0] RegDst, MEM_size;
        logic [4:0] ALUControl;
        logic       instr_done, error;
    } ctl_t;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2,
                           ALU_OR  = 5'd3, ALU_XOR = 5'd4, ALU_NOR = 5'd5,
                           ALU_SLT = 5'd6, ALU_SLL = 5'd7, ALU_SRL = 5'd8,
                           ALU_SRA = 5'd9, ALU_LUI = 5'd10;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctl_t             c;
    logic             timeout;

    // Supported R-type functions; anything else traps at decode.
    function automatic logic r_legal(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] r_alu(input logic [5:0] f);
        case (f)
            6'h22, 6'h23: return ALU_SUB;
            6'h24:        return ALU_AND;
            6'h25:        return ALU_OR;
            6'h26:        return ALU_XOR;
            6'h27:        return ALU_NOR;
            6'h2A, 6'h2B: return ALU_SLT;
            6'h00:        return ALU_SLL;
            6'h02:        return ALU_SRL;
            6'h03:        return ALU_SRA;
            default:      return ALU_ADD;
        endcase
    endfunction

    // Byte ops (lb/lbu/sb) end in 0 or 4 of the low 3 bits, halves in 1 or 5.
    function automatic logic [1:0] mem_size(input logic [5:0] op);
        case (op[1:0])
            2'b00:   return 2'b10;
            2'b01:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    assign timeout = (cnt_q >= TMO);

    // State, latched instruction fields and the memory wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Moore outputs; the counter only survives req&!ready cycles,
    // so it is zero on entry to every req state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        cnt_d   = '0;
        c       = '0;
        case (state_q)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.ALUSrcB = 2'b01;
                if (bus.mem_ready) begin
                    c.IRWrite = 1'b1;
                    c.PCWrite = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) state_d = S_TRAP;
                else cnt_d = cnt_q + 1'b1;
            end
            S_DECODE: begin
                op_d      = bus.opcode;
                fn_d      = bus.funct;
                c.ALUSrcB = 2'b11;
                case (bus.opcode)
                    6'h00: state_d = !r_legal(bus.funct) ? S_TRAP :
                                     (bus.funct == 6'h08 || bus.funct == 6'h09) ? S_JUMP : S_R_EXEC;
                    6'h02, 6'h03:                      state_d = S_JUMP;
                    6'h04, 6'h05, 6'h06, 6'h07:        state_d = S_BRANCH;
                    6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F:        state_d = S_I_EXEC;
                    6'h20, 6'h21, 6'h23, 6'h24,
                    6'h25, 6'h28, 6'h29, 6'h2B:        state_d = S_MEM_ADDR;
                    default:                           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                c.ALUSrcA = 1'b1;
                c.ALUSrcB = 2'b10;
                state_d   = op_q[3] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                c.mem_req     = 1'b1;
                c.IorD        = 1'b1;
                c.MEM_size    = mem_size(op_q);
                c.unsigned_op = (op_q == 6'h24) || (op_q == 6'h25);
                if (bus.mem_ready) state_d = S_MEM_WB;
                else if (timeout)  state_d = S_TRAP;
                else               cnt_d   = cnt_q + 1'b1;
            end
            S_MEM_WB: begin
                c.RegWrite   = 1'b1;
                c.MemToReg   = 1'b1;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                c.mem_req  = 1'b1;
                c.MemWrite = 1'b1;
                c.IorD     = 1'b1;
                c.MEM_size = mem_size(op_q);
                if (bus.mem_ready) begin
                    c.instr_done = 1'b1;
                    state_d      = S_FETCH;
                end else if (timeout) state_d = S_TRAP;
                else cnt_d = cnt_q + 1'b1;
            end
            S_R_EXEC: begin
                c.ALUSrcA     = 1'b1;
                c.ALUControl  = r_alu(fn_q);
                c.unsigned_op = (fn_q == 6'h21) || (fn_q == 6'h23) || (fn_q == 6'h2B);
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                c.RegWrite   = 1'b1;
                c.RegDst     = 2'b01;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_I_EXEC: begin
                c.ALUSrcA = 1'b1;
                c.ALUSrcB = 2'b10;
                case (op_q[2:0])
                    3'd0:    c.ALUControl = ALU_ADD;
                    3'd1:    begin c.ALUControl = ALU_ADD; c.unsigned_op = 1'b1; end
                    3'd2:    c.ALUControl = ALU_SLT;
                    3'd3:    begin c.ALUControl = ALU_SLT; c.unsigned_op = 1'b1; end
                    3'd4:    begin c.ALUControl = ALU_AND; c.unsigned_op = 1'b1; end
                    3'd5:    begin c.ALUControl = ALU_OR;  c.unsigned_op = 1'b1; end
                    3'd6:    begin c.ALUControl = ALU_XOR; c.unsigned_op = 1'b1; end
                    default: c.ALUControl = ALU_LUI;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                c.RegWrite   = 1'b1;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                c.ALUSrcA    = 1'b1;
                c.ALUControl = ALU_SUB;
                c.PCSource   = 2'b01;
                c.Branch     = 3'({1'b0, op_q[1:0]} + 3'd1);
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                c.PCWrite    = 1'b1;
                c.instr_done = 1'b1;
                state_d      = S_FETCH;
                if (op_q == 6'h00) begin
                    c.PCSource = 2'b11;
                    if (fn_q == 6'h09) begin
                        c.RegWrite = 1'b1;
                        c.RegDst   = 2'b01;
                    end
                end else begin
                    c.PCSource = 2'b10;
                    if (op_q == 6'h03) begin
                        c.RegWrite = 1'b1;
                        c.RegDst   = 2'b10;
                    end
                end
            end
            S_TRAP:  c.error = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    // Outputs are gated by rst_n so a reset mid-access drops strobes at once.
    ctl_t o;
    assign o               = rst_n ? c : '0;
    assign bus.mem_req     = o.mem_req;
    assign bus.MemWrite    = o.MemWrite;
    assign bus.IRWrite     = o.IRWrite;
    assign bus.PCWrite     = o.PCWrite;
    assign bus.IorD        = o.IorD;
    assign bus.RegWrite    = o.RegWrite;
    assign bus.MemToReg    = o.MemToReg;
    assign bus.ALUSrcA     = o.ALUSrcA;
    assign bus.unsigned_op = o.unsigned_op;
    assign bus.ALUSrcB     = o.ALUSrcB;
    assign bus.PCSource    = o.PCSource;
    assign bus.Branch      = o.Branch;
    assign bus.RegDst      = o.RegDst;
    assign bus.MEM_size    = o.MEM_size;
    assign bus.ALUControl  = o.ALUControl;
    assign bus.instr_done  = o.instr_done;
    assign bus.error       = o.error;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: inputs change on the falling
// edge, outputs are sampled 1 time unit later.
module tb_mips_multicycle_control;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // All outputs packed together, used to confirm "everything is zero".
    function automatic logic [30:0] all_outs();
        return {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.IorD,
                bus.RegWrite, bus.MemToReg, bus.ALUSrcA, bus.unsigned_op,
                bus.ALUSrcB, bus.PCSource, bus.Branch, bus.RegDst, bus.MEM_size,
                bus.ALUControl, bus.state, bus.instr_done, bus.error};
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 31'd0) begin
            errors++; $display("FAIL reset_outs: got %h exp 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.mem_req !== 1'b1 || bus.ALUSrcB !== 2'b01) begin
            errors++; $display("FAIL reset_first_fetch: got st=%0d req=%b srcb=%b exp 0 1 01",
                               bus.state, bus.mem_req, bus.ALUSrcB);
        end
        @(negedge clk);
    endtask

    task automatic test_r_add();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        int dones = 0;
        do_reset();
        bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.state !== exp_st[i]) begin
                errors++; $display("FAIL r_add_state[%0d]: got %0d exp %0d", i, bus.state, exp_st[i]);
            end
            if (i == 0) begin
                checks++;
                if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
                    errors++; $display("FAIL fetch_strobes: got ir=%b pc=%b exp 1 1", bus.IRWrite, bus.PCWrite);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00 || bus.ALUControl !== 5'd0) begin
                    errors++; $display("FAIL r_exec_sel: got a=%b b=%b alu=%0d exp 1 00 0",
                                       bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b01) begin
                    errors++; $display("FAIL r_wb: got rw=%b rd=%b exp 1 01", bus.RegWrite, bus.RegDst);
                end
            end
            if (bus.instr_done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL r_add_done_count: got %0d exp 1", dones);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp_st [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        int reqs = 0;
        do_reset();
        bus.opcode = 6'h23; bus.funct = 6'h00;
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = (i == 0 || i >= 6);
            if (i >= 2) bus.opcode = 6'h3F;   // must be ignored outside DECODE
            #1;
            checks++;
            if (bus.state !== exp_st[i]) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d exp %0d", i, bus.state, exp_st[i]);
            end
            if (bus.state === 4'd3 && bus.mem_req === 1'b1 && bus.IorD === 1'b1
                && bus.MEM_size === 2'b00) reqs++;
            if (i == 7) begin
                checks++;
                if (bus.MemToReg !== 1'b1 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b00
                    || bus.instr_done !== 1'b1) begin
                    errors++; $display("FAIL lw_wb: got m2r=%b rw=%b rd=%b done=%b exp 1 1 00 1",
                                       bus.MemToReg, bus.RegWrite, bus.RegDst, bus.instr_done);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (reqs !== 4) begin
            errors++; $display("FAIL lw_req_cycles: got %0d exp 4", reqs);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{6'h04, 6'h07};
        logic [2:0] brs [2] = '{3'b001, 3'b100};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.opcode = ops[k]; bus.mem_ready = 1'b1;
            @(negedge clk); @(negedge clk);
            #1;
            checks++;
            if (bus.state !== 4'd10 || bus.Branch !== brs[k] || bus.ALUControl !== 5'd1
                || bus.PCSource !== 2'b01 || bus.instr_done !== 1'b1 || bus.PCWrite !== 1'b0) begin
                errors++; $display("FAIL branch_%0h: got st=%0d br=%b alu=%0d pcs=%b done=%b pcw=%b exp 10 %b 1 01 1 0",
                                   ops[k], bus.state, bus.Branch, bus.ALUControl, bus.PCSource,
                                   bus.instr_done, bus.PCWrite, brs[k]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.state !== 4'd0) begin
                errors++; $display("FAIL branch_return: got %0d exp 0", bus.state);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        bus.opcode = 6'h03; bus.mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd11 || bus.PCWrite !== 1'b1 || bus.PCSource !== 2'b10
            || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b10) begin
            errors++; $display("FAIL jal: got st=%0d pcw=%b pcs=%b rw=%b rd=%b exp 11 1 10 1 10",
                               bus.state, bus.PCWrite, bus.PCSource, bus.RegWrite, bus.RegDst);
        end
        do_reset();
        bus.opcode = 6'h00; bus.funct = 6'h08; bus.mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd11 || bus.PCSource !== 2'b11 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL jr: got st=%0d pcs=%b rw=%b exp 11 11 0",
                               bus.state, bus.PCSource, bus.RegWrite);
        end
    endtask

    task automatic test_itype();
        do_reset();
        bus.opcode = 6'h0D; bus.mem_ready = 1'b1;   // ori
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd8 || bus.ALUControl !== 5'd3 || bus.unsigned_op !== 1'b1
            || bus.ALUSrcB !== 2'b10) begin
            errors++; $display("FAIL ori_exec: got st=%0d alu=%0d uns=%b srcb=%b exp 8 3 1 10",
                               bus.state, bus.ALUControl, bus.unsigned_op, bus.ALUSrcB);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd9 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b00) begin
            errors++; $display("FAIL ori_wb: got st=%0d rw=%b rd=%b exp 9 1 00",
                               bus.state, bus.RegWrite, bus.RegDst);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'h3F, 6'h00};
        logic [5:0] fns [2] = '{6'h00, 6'h01};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.opcode = ops[k]; bus.funct = fns[k]; bus.mem_ready = 1'b1;
            @(negedge clk); @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (bus.state !== 4'd12 || bus.error !== 1'b1 || bus.mem_req !== 1'b0) begin
                    errors++; $display("FAIL illegal_%0d[%0d]: got st=%0d err=%b req=%b exp 12 1 0",
                                       k, i, bus.state, bus.error, bus.mem_req);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sw_timeout();
        int wr = 0;
        int i  = 0;
        do_reset();
        bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
        while (i < 60) begin
            #1;
            if (bus.state === 4'd12) break;
            if (bus.state === 4'd5 && bus.mem_req === 1'b1 && bus.MemWrite === 1'b1) wr++;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            i++;
        end
        checks++;
        if (bus.state !== 4'd12 || bus.error !== 1'b1 || wr !== TMO + 1) begin
            errors++; $display("FAIL sw_timeout: got st=%0d err=%b wr_cycles=%0d exp 12 1 %0d",
                               bus.state, bus.error, wr, TMO + 1);
        end
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd12 || bus.error !== 1'b1) begin
            errors++; $display("FAIL trap_sticky: got st=%0d err=%b exp 12 1", bus.state, bus.error);
        end
        do_reset();
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.error !== 1'b0) begin
            errors++; $display("FAIL trap_reset_clear: got st=%0d err=%b exp 0 0", bus.state, bus.error);
        end
    endtask

    task automatic test_sw_boundary();
        do_reset();
        bus.opcode = 6'h29;   // sh
        for (int i = 0; i < 21; i++) begin
            bus.mem_ready = (i == 0 || i == 3 + TMO);
            #1;
            if (i == 3) begin
                checks++;
                if (bus.MEM_size !== 2'b01 || bus.MemWrite !== 1'b1) begin
                    errors++; $display("FAIL sh_size: got sz=%b mw=%b exp 01 1", bus.MEM_size, bus.MemWrite);
                end
            end
            if (i == 3 + TMO) begin
                checks++;
                if (bus.state !== 4'd5 || bus.instr_done !== 1'b1) begin
                    errors++; $display("FAIL ready_at_limit: got st=%0d done=%b exp 5 1", bus.state, bus.instr_done);
                end
            end
            if (i == 4 + TMO) begin
                checks++;
                if (bus.state !== 4'd0 || bus.error !== 1'b0) begin
                    errors++; $display("FAIL after_limit: got st=%0d err=%b exp 0 0", bus.state, bus.error);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        repeat (4) @(negedge clk);   // two MEM_WR wait cycles done
        #2;
        checks++;
        if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1) begin
            errors++; $display("FAIL pre_reset_wr: got st=%0d mw=%b exp 5 1", bus.state, bus.MemWrite);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 31'd0) begin
            errors++; $display("FAIL mid_reset_outs: got %h exp 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.state !== 4'd0 || bus.mem_req !== 1'b1 || bus.MemWrite !== 1'b0) begin
                errors++; $display("FAIL post_reset_fetch[%0d]: got st=%0d req=%b mw=%b exp 0 1 0",
                                   i, bus.state, bus.mem_req, bus.MemWrite);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_r_add();
        test_lw_wait();
        test_branch();
        test_jump();
        test_itype();
        test_illegal();
        test_sw_timeout();
        test_sw_boundary();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle successor to the single-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back over several clocks and shares one memory port through a req/ready handshake. It sits between the instruction register and the multi-cycle datapath and drives all datapath enables, mux selects and ALU control. Memory latency is variable and bounded by a parameterised timeout. Illegal opcodes and memory timeouts trap to a sticky error state.

## Interface
- MEM_TIMEOUT, 16: max cycles `mem_req` may wait for `mem_ready` before trapping (≥1).
- CNT_W, 5: wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; sampled in DECODE only.
- funct  in  6  IR[5:0]; sampled in DECODE only.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req, MemWrite, IRWrite, PCWrite, IorD, RegWrite, MemToReg, ALUSrcA, unsigned_op  out  1 each  standard multi-cycle strobes/selects.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 reg A (jr/jalr).
- Branch  out  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz; datapath loads PC when condition holds.
- RegDst  out  2  00 rt, 01 rd, 10 $ra.
- MEM_size  out  2  00 word, 01 half, 10 byte.
- ALUControl  out  5  00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 nor, 00110 slt, 00111 sll, 01000 srl, 01001 sra, 01010 lui.
- state  out  4  current state (debug).
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- error  out  1  high in TRAP.

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, TRAP 12. All outputs are 0 except as listed.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSource=00, MEM_size=00. IRWrite=PCWrite=1 only in the mem_ready cycle, then -> DECODE.
- DECODE: latch opcode/funct; ALUSrcB=11, add (branch target to ALUOut). Next by opcode: 0x00 -> R_EXEC (funct 0x08 jr / 0x09 jalr -> JUMP); 0x02/0x03 -> JUMP; 0x04-0x07 -> BRANCH; 0x08-0x0F -> I_EXEC; 0x20,0x21,0x23,0x24,0x25,0x28,0x29,0x2B -> MEM_ADDR; anything else, or an undefined R funct -> TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add; loads -> MEM_RD, stores -> MEM_WR.
- MEM_RD: mem_req=1, IorD=1, MEM_size/unsigned_op from opcode (lbu/lhu unsigned); on ready -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemToReg=1, instr_done=1 -> FETCH.
- MEM_WR: mem_req=1, MemWrite=1, IorD=1, MEM_size per opcode; on ready: instr_done=1 -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (0x20/21 add, 0x22/23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A/2B slt, 0x00 sll, 0x02 srl, 0x03 sra); unsigned_op for addu/subu/sltu -> R_WB.
- R_WB: RegWrite=1, RegDst=01, instr_done=1 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10; addi/addiu add, slti/sltiu slt, andi/ori/xori logic with unsigned_op=1 (zero-extend), lui op, sltiu/addiu unsigned_op=1 -> I_WB.
- I_WB: RegWrite=1, RegDst=00, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, Branch per opcode, instr_done=1 -> FETCH.
- JUMP: PCWrite=1; PCSource=10 (j/jal) or 11 (jr/jalr); jal: RegWrite=1, RegDst=10, PC+4 to $ra; jalr: RegWrite=1, RegDst=01; instr_done=1 -> FETCH.
- TRAP: error=1, all other outputs 0; exit only via reset.

## Timing
- Reset (async assert): state=FETCH, latched opcode/funct=0, wait counter=0, and every output forced to 0 while rst_n=0. First mem_req is in the first cycle after rst_n deasserts.
- Latency with zero-wait memory (ready in the first req cycle): R/I-type 4, lw 5, sw 4, branch 3, jump 3 cycles.
- Handshake: mem_req stays high and address selects hold until mem_ready is seen. mem_ready while mem_req=0 is ignored. Access completes on the cycle where req&ready.
- Wait counter clears on entry to any req state and increments each cycle req&!ready. If the count reaches MEM_TIMEOUT with ready still low -> TRAP next cycle. Ready arriving in the cycle the count reaches MEM_TIMEOUT completes normally (ready has priority).
- Opcode/funct changes outside DECODE have no effect.
- Reset mid-access drops mem_req immediately (asynchronously); no write strobe is issued afterwards.

## Test plan
- Reset, then R add (op 0, funct 0x20), ready held 1: states 0,1,6,7,0; RegWrite/RegDst=01 in state 7; instr_done pulses once; 4 cycles total.
- lw (0x23) with ready delayed 3 cycles in MEM_RD: mem_req high 4 cycles with IorD=1; then MEM_WB with MemToReg=1; 8 cycles including fetch.
- beq (0x04): BRANCH state drives Branch=001, ALUControl=00001, PCSource=01, done after 3 cycles; bgtz (0x07) gives Branch=100.
- jal (0x03): JUMP state drives PCWrite=1, PCSource=10, RegWrite=1, RegDst=10.
- Illegal opcode 0x3F, then sw with ready never asserted: TRAP, error=1; sw traps after MEM_TIMEOUT=16 wait cycles; only reset clears it.
- rst_n pulsed low in the middle of a MEM_WR wait: outputs go to 0 immediately; after release, FETCH asserts mem_req with MemWrite=0.
